// File: rtl/ultrasonic_pkg.sv
//==============================================================================
// Module   : ultrasonic_pkg
// Brief    : Shared types and default timing constants for the ultrasonic
//            echo emulator and its sensor-controller counterpart.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ultrasonic_pkg;

    // Responder protocol states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG_HIGH = 3'd1,
        BURST     = 3'd2,
        ECHO      = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    // Default timings at a 100 MHz clock
    localparam int c_DEF_TRIG_MIN_CYCLES = 1000;     // 10 us trigger
    localparam int c_DEF_BURST_CYCLES    = 20000;    // 200 us burst
    localparam int c_DEF_CYCLES_PER_CM   = 5800;     // 58 us per cm
    localparam int c_DEF_MAX_CM          = 400;
    localparam int c_DEF_TIMEOUT_CYCLES  = 3800000;  // 38 ms no-object echo
    localparam int c_DEF_HOLDOFF_CYCLES  = 6000000;  // 60 ms dead time

    // Larger of two integers, used for sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/echo_width_gen.sv
//==============================================================================
// Module   : echo_width_gen
// Brief    : Generates an echo-high window of cm*CYCLES_PER_CM cycles using a
//            tick counter nested under a cm down-counter (no multiplier).
//            Out-of-range distances produce a TIMEOUT_CYCLES window.
//            active rises on the edge that samples start and falls on the
//            edge that samples done.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module echo_width_gen
    import ultrasonic_pkg::*;
#(
    parameter int CYCLES_PER_CM  = c_DEF_CYCLES_PER_CM,
    parameter int MAX_CM         = c_DEF_MAX_CM,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cm,
    output logic        done,
    output logic        active
);

    localparam int c_TICK_W = $clog2(max_int(max_int(CYCLES_PER_CM, TIMEOUT_CYCLES), 2));
    localparam int c_CM_W   = $clog2(MAX_CM + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_CM_LAST = c_TICK_W'(CYCLES_PER_CM - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_TO_LAST = c_TICK_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE     = c_TICK_W'(1);
    localparam logic [c_CM_W-1:0]   c_CM_ONE       = c_CM_W'(1);
    localparam logic [15:0]         c_MAX_CM_16    = 16'(MAX_CM);

    logic                r_active;
    logic                r_timeout;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_CM_W-1:0]   r_cm_cnt;

    logic w_in_range;
    logic w_tick_last;
    logic w_cm_last;

    // A timeout window is a single "cm" whose tick period is TIMEOUT_CYCLES
    assign w_in_range  = (cm != 16'd0) && (cm <= c_MAX_CM_16);
    assign w_tick_last = r_timeout ? (r_tick == c_TICK_TO_LAST) : (r_tick == c_TICK_CM_LAST);
    assign w_cm_last   = (r_cm_cnt == c_CM_ONE);

    assign done   = r_active && w_tick_last && w_cm_last;
    assign active = r_active;

    // Load on start, then tick through each cm until the last tick of the last cm
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_timeout <= 1'b0;
            r_tick    <= '0;
            r_cm_cnt  <= '0;
        end else if (start) begin
            r_active  <= 1'b1;
            r_timeout <= !w_in_range;
            r_tick    <= '0;
            r_cm_cnt  <= w_in_range ? c_CM_W'(cm) : c_CM_ONE;
        end else if (r_active) begin
            if (w_tick_last) begin
                r_tick <= '0;
                if (w_cm_last) begin
                    r_active <= 1'b0;
                end else begin
                    r_cm_cnt <= r_cm_cnt - c_CM_ONE;
                end
            end else begin
                r_tick <= r_tick + c_TICK_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ultrasonic_echo_emulator.sv
//==============================================================================
// Module   : ultrasonic_echo_emulator
// Brief    : Responder side of an HC-SR04-style trigger/echo sensor. Validates
//            the trigger width, waits a burst delay, emits an echo pulse whose
//            width encodes TARGET_CM, then enforces a hold-off period.
//            Optional: ULTRASONIC_TRIG_SYNC_EN adds a two-flop synchronizer on
//            TRIGGER_IN (all trigger-referenced timings shift by +2 cycles).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter int TRIG_MIN_CYCLES = c_DEF_TRIG_MIN_CYCLES,
    parameter int BURST_CYCLES    = c_DEF_BURST_CYCLES,
    parameter int CYCLES_PER_CM   = c_DEF_CYCLES_PER_CM,
    parameter int MAX_CM          = c_DEF_MAX_CM,
    parameter int TIMEOUT_CYCLES  = c_DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES  = c_DEF_HOLDOFF_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        TRIGGER_IN,
    input  logic [15:0] TARGET_CM,
    output logic        ECHO_OUT,
    output logic        BUSY,
    output logic        TRIG_ERR,
    output logic [15:0] ECHO_COUNT
);

    // One shared counter covers trigger width, burst delay and hold-off
    localparam int c_CNT_W = $clog2(max_int(max_int(TRIG_MIN_CYCLES, BURST_CYCLES),
                                            HOLDOFF_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TRIG_MIN   = c_CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(BURST_CYCLES);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLDOFF_CYCLES - 1);

    state_t               r_state, w_state_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [15:0]          r_cm, w_cm_next;
    logic                 r_trig_err, w_trig_err_next;
    logic [15:0]          r_echo_count, w_echo_count_next;
    logic                 w_gen_start;
    logic                 w_gen_done;
    logic                 w_gen_active;
    logic                 w_trig;

`ifdef ULTRASONIC_TRIG_SYNC_EN
    logic [1:0] r_trig_sync;

    // Two-flop synchronizer for a trigger driven from another clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trig_sync <= 2'b00;
        end else begin
            r_trig_sync <= {r_trig_sync[0], TRIGGER_IN};
        end
    end

    assign w_trig = r_trig_sync[1];
`else
    assign w_trig = TRIGGER_IN;
`endif

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cm         <= '0;
            r_trig_err   <= 1'b0;
            r_echo_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_cm         <= w_cm_next;
            r_trig_err   <= w_trig_err_next;
            r_echo_count <= w_echo_count_next;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_cm_next         = r_cm;
        w_trig_err_next   = 1'b0;
        w_echo_count_next = r_echo_count;
        w_gen_start       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_next = TRIG_HIGH;
                    w_cnt_next   = c_ONE;
                end
            end

            TRIG_HIGH: begin
                if (w_trig) begin
                    // Saturate so an indefinitely held trigger is still accepted
                    if (r_cnt < c_TRIG_MIN) begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end else if (r_cnt >= c_TRIG_MIN) begin
                    w_state_next = BURST;
                    w_cnt_next   = '0;
                    w_cm_next    = TARGET_CM;
                end else begin
                    w_state_next    = IDLE;
                    w_cnt_next      = '0;
                    w_trig_err_next = 1'b1;
                end
            end

            BURST: begin
                if (r_cnt == c_BURST_LAST) begin
                    w_state_next = ECHO;
                    w_cnt_next   = '0;
                    w_gen_start  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_ONE;
                end
            end

            ECHO: begin
                if (w_gen_done) begin
                    w_state_next      = HOLDOFF;
                    w_cnt_next        = '0;
                    w_echo_count_next = r_echo_count + 16'd1;
                end
            end

            HOLDOFF: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_ONE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    echo_width_gen #(
        .CYCLES_PER_CM  (CYCLES_PER_CM),
        .MAX_CM         (MAX_CM),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_echo_width_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_gen_start),
        .cm     (r_cm),
        .done   (w_gen_done),
        .active (w_gen_active)
    );

    // The generator's active flag is registered and spans exactly the echo window
    assign ECHO_OUT   = w_gen_active;
    assign BUSY       = (r_state != IDLE);
    assign TRIG_ERR   = r_trig_err;
    assign ECHO_COUNT = r_echo_count;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_echo_emulator.sv
//==============================================================================
// Module   : tb_ultrasonic_echo_emulator
// Brief    : Self-checking bench for ultrasonic_echo_emulator with small
//            timing parameters and an echo-width scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ultrasonic_echo_emulator;

    localparam int c_TRIG_MIN = 10;
    localparam int c_BURST    = 20;
    localparam int c_CPC      = 4;
    localparam int c_MAX_CM   = 400;
    localparam int c_TIMEOUT  = 100;
    localparam int c_HOLDOFF  = 50;

    typedef struct {
        int width;
        int count;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        TRIGGER_IN;
    logic [15:0] TARGET_CM;
    logic        ECHO_OUT;
    logic        BUSY;
    logic        TRIG_ERR;
    logic [15:0] ECHO_COUNT;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;
    int   exp_count;
    int   err_pulses;

    ultrasonic_echo_emulator #(
        .TRIG_MIN_CYCLES (c_TRIG_MIN),
        .BURST_CYCLES    (c_BURST),
        .CYCLES_PER_CM   (c_CPC),
        .MAX_CM          (c_MAX_CM),
        .TIMEOUT_CYCLES  (c_TIMEOUT),
        .HOLDOFF_CYCLES  (c_HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .TRIGGER_IN (TRIGGER_IN),
        .TARGET_CM  (TARGET_CM),
        .ECHO_OUT   (ECHO_OUT),
        .BUSY       (BUSY),
        .TRIG_ERR   (TRIG_ERR),
        .ECHO_COUNT (ECHO_COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected echo width for a programmed distance
    function automatic int model_width(input int cm);
        if (cm >= 1 && cm <= c_MAX_CM) return cm * c_CPC;
        return c_TIMEOUT;
    endfunction

    // Echo monitor: measures each echo pulse and pops the scoreboard on its fall
    initial begin : monitor
        int   w;
        bit   in_echo;
        exp_t e;
        w = 0;
        in_echo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                w = 0;
                in_echo = 1'b0;
            end else begin
                if (ECHO_OUT === 1'b1) begin
                    in_echo = 1'b1;
                    w++;
                end else if (in_echo) begin
                    in_echo = 1'b0;
                    n_vec++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_echo: width %0d, no echo expected", w);
                    end else begin
                        e = sb_q.pop_front();
                        if (w !== e.width) begin
                            n_err++;
                            $display("FAIL echo_width: got %0d, expected %0d", w, e.width);
                        end
                        n_vec++;
                        if (ECHO_COUNT !== 16'(e.count)) begin
                            n_err++;
                            $display("FAIL echo_count_at_fall: got %0d, expected %0d", ECHO_COUNT, e.count);
                        end
                    end
                    w = 0;
                end
                if (TRIG_ERR === 1'b1) err_pulses++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Raise the trigger for hi sampling edges; the next edge is edge N
    task automatic pulse_trig(input int hi);
        @(posedge clk);
        #1 TRIGGER_IN = 1'b1;
        repeat (hi) @(posedge clk);
        #1 TRIGGER_IN = 1'b0;
    endtask

    task automatic expect_echo(input int cm);
        exp_t e;
        exp_count++;
        e.width = model_width(cm);
        e.count = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (BUSY === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_idle_timeout: BUSY still %b after %0d cycles, expected 0", tag, BUSY, budget);
        end
    endtask

    task automatic wait_echo(input logic lvl, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ECHO_OUT === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_echo_wait: ECHO_OUT %b after %0d cycles, expected %b", tag, ECHO_OUT, budget, lvl);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        exp_count = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        TRIGGER_IN = 1'b0;
        TARGET_CM = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ECHO_OUT, BUSY, TRIG_ERR, ECHO_COUNT} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: echo=%b busy=%b err=%b count=%0d, expected all 0",
                     ECHO_OUT, BUSY, TRIG_ERR, ECHO_COUNT);
        end
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_basic();
        int lat;
        int err0;
        err0 = err_pulses;
        TARGET_CM = 16'd25;
        expect_echo(25);
        pulse_trig(c_TRIG_MIN);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ECHO_OUT === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat !== c_BURST + 1) begin
            n_err++;
            $display("FAIL basic_latency: echo rose at N+%0d, expected N+%0d", lat, c_BURST + 1);
        end
        wait_idle(400, "basic");
        n_vec++;
        if (ECHO_COUNT !== 16'd1) begin
            n_err++;
            $display("FAIL basic_count: got %0d, expected 1", ECHO_COUNT);
        end
        n_vec++;
        if (err_pulses !== err0) begin
            n_err++;
            $display("FAIL basic_no_err: TRIG_ERR pulses %0d, expected 0", err_pulses - err0);
        end
    endtask

    task automatic test_short_trigger();
        int  err0;
        bit  echo_seen;
        err0 = err_pulses;
        TARGET_CM = 16'd25;
        pulse_trig(c_TRIG_MIN - 1);
        @(posedge clk);
        #1;
        n_vec++;
        if (TRIG_ERR !== 1'b1 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL short_err_edge: err=%b busy=%b, expected err=1 busy=0", TRIG_ERR, BUSY);
        end
        echo_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ECHO_OUT !== 1'b0) echo_seen = 1'b1;
        end
        n_vec++;
        if (err_pulses - err0 !== 1) begin
            n_err++;
            $display("FAIL short_err_width: TRIG_ERR high %0d cycles, expected 1", err_pulses - err0);
        end
        n_vec++;
        if (echo_seen) begin
            n_err++;
            $display("FAIL short_no_echo: ECHO_OUT rose, expected 0");
        end
    endtask

    task automatic test_out_of_range();
        int cms[3];
        cms[0] = 0;
        cms[1] = 401;
        cms[2] = 400;
        foreach (cms[i]) begin
            TARGET_CM = 16'(cms[i]);
            expect_echo(cms[i]);
            pulse_trig(c_TRIG_MIN);
            wait_idle(2000, "range");
        end
        n_vec++;
        if (ECHO_COUNT !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL range_count: got %0d, expected %0d", ECHO_COUNT, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        TARGET_CM = 16'd10;
        expect_echo(10);
        pulse_trig(c_TRIG_MIN);
        wait_echo(1'b1, 60, "b2b_rise");
        pulse_trig(c_TRIG_MIN);
        wait_echo(1'b0, 100, "b2b_fall");
        pulse_trig(c_TRIG_MIN);
        wait_idle(200, "b2b");
        n_vec++;
        if (ECHO_COUNT !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_ignored: count %0d, expected 1", ECHO_COUNT);
        end
        expect_echo(10);
        pulse_trig(c_TRIG_MIN);
        wait_idle(300, "b2b_second");
        n_vec++;
        if (ECHO_COUNT !== 16'd2) begin
            n_err++;
            $display("FAIL b2b_second: count %0d, expected 2", ECHO_COUNT);
        end
    endtask

    task automatic test_reset_mid_echo();
        TARGET_CM = 16'd25;
        expect_echo(25);
        pulse_trig(c_TRIG_MIN);
        wait_echo(1'b1, 60, "rst_rise");
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (ECHO_OUT !== 1'b0 || BUSY !== 1'b0 || ECHO_COUNT !== 16'd0) begin
            n_err++;
            $display("FAIL mid_echo_reset: echo=%b busy=%b count=%0d, expected 0 0 0",
                     ECHO_OUT, BUSY, ECHO_COUNT);
        end
        rst_n = 1'b1;
        sb_q.delete();
        exp_count = 0;
        TARGET_CM = 16'd3;
        expect_echo(3);
        pulse_trig(c_TRIG_MIN);
        wait_idle(300, "after_reset");
        n_vec++;
        if (ECHO_COUNT !== 16'd1) begin
            n_err++;
            $display("FAIL after_reset_count: got %0d, expected 1", ECHO_COUNT);
        end
    endtask

    task automatic test_target_change();
        TARGET_CM = 16'd25;
        expect_echo(25);
        pulse_trig(c_TRIG_MIN);
        repeat (5) @(posedge clk);
        #1 TARGET_CM = 16'd3;
        wait_idle(400, "latch");
    endtask

    initial begin : main
        n_vec = 0;
        n_err = 0;
        err_pulses = 0;
        test_reset();
        test_basic();
        test_short_trigger();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_echo();
        test_target_change();
        repeat (5) @(posedge clk);
        n_vec++;
        if (sb_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d echoes outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
